// File: rtl/fetch_unit.sv
// Instruction fetch: one-cycle PC-to-bus ADDR phase, then a memory request held until memReady; the word is valid 2 cycles after pcOutEn at best.
// New fetches stall while the buffer plus the in-flight fetch reaches DEPTH (DEPTH=2 with FETCH_PREFETCH_EN, otherwise 1).
module fetch_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus,
  output logic             pcOutEn,
  output logic             pcCount,
  output logic             memReq,
  output logic [WIDTH-1:0] memAddr,
  input  logic             memReady,
  input  logic [WIDTH-1:0] memData,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instrAddr,
  output logic             instrValid,
  input  logic             instrAccept,
  input  logic             halt,
  input  logic             flush
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, MEM} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] addr;
  } entry_t;

  state_t     state;
  logic       discard;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic [1:0] wr_idx;
  entry_t     ent     [DEPTH];
  entry_t     ent_nxt [DEPTH];
  logic       start;
  logic       complete;
  logic       push;
  logic       pop;

  // Only one fetch can be in flight, and never while IDLE, so occupancy is just cnt here.
  assign start    = (state == IDLE) && !halt && !flush && (cnt < DEPTH_C);
  assign complete = (state == MEM) && memReady;
  assign push     = complete && !discard && !flush;
  assign pop      = instrValid && instrAccept && !flush;
  assign wr_idx   = cnt - 2'(pop);

  // Shift buffer: slot 0 is always the head, so instr/instrAddr come straight from flops.
  always_comb begin
    cnt_nxt = cnt;
    for (int i = 0; i < DEPTH; i++) ent_nxt[i] = ent[i];
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i < DEPTH - 1) ent_nxt[i] = ent[(i + 1) % DEPTH];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 2'(i)) ent_nxt[i] = '{data: memData, addr: memAddr};
        end
      end
      cnt_nxt = cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      discard    <= 1'b0;
      cnt        <= '0;
      pcOutEn    <= 1'b0;
      pcCount    <= 1'b0;
      memReq     <= 1'b0;
      memAddr    <= '0;
      instrValid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      cnt        <= cnt_nxt;
      instrValid <= (cnt_nxt != 2'd0);
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      pcCount    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ADDR;
            pcOutEn <= 1'b1;
          end
        end
        ADDR: begin
          state   <= MEM;
          pcOutEn <= 1'b0;
          pcCount <= 1'b1;
          memReq  <= 1'b1;
          memAddr <= bus;
          if (flush) discard <= 1'b1;
        end
        MEM: begin
          // The memory handshake is never aborted; a flushed fetch just drops its data.
          if (memReady) begin
            state   <= IDLE;
            memReq  <= 1'b0;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr     = ent[0].data;
  assign instrAddr = ent[0].addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench acts as PC and program memory, and a queue-based model predicts every output each cycle.
module tb_fetch_unit;
  localparam int WIDTH = 16;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] bus;
  logic             pcOutEn;
  logic             pcCount;
  logic             memReq;
  logic [WIDTH-1:0] memAddr;
  logic             memReady;
  logic [WIDTH-1:0] memData;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instrAddr;
  logic             instrValid;
  logic             instrAccept;
  logic             halt;
  logic             flush;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pcOutEn(pcOutEn), .pcCount(pcCount), .memReq(memReq), .memAddr(memAddr),
    .memReady(memReady), .memData(memData),
    .instr(instr), .instrAddr(instrAddr), .instrValid(instrValid),
    .instrAccept(instrAccept), .halt(halt), .flush(flush)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] addr;
  } ent_t;

  ent_t             q[$];
  bit               m_addr, m_mem, m_first, m_disc;
  logic [WIDTH-1:0] m_cur, m_next, pc;
  bit               ovr_en;
  logic [WIDTH-1:0] ovr;
  int               n_chk = 0;
  int               n_fail = 0;
  int               pulses, req_cycles, addr_cycles, valid_cycles;

  function automatic logic [WIDTH-1:0] mem_fn(input logic [WIDTH-1:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_addr  = 0;
    m_mem   = 0;
    m_first = 0;
    m_disc  = 0;
  endtask

  // Effect of one rising edge, given the inputs held during the cycle before it.
  task automatic model_edge(input bit h, input bit f, input bit r, input bit a);
    bit start, complete, push, pop;
    start    = !m_addr && !m_mem && !h && !f && (q.size() < DEPTH);
    complete = m_mem && r;
    push     = complete && !m_disc && !f;
    pop      = (q.size() != 0) && a && !f;
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{data: (ovr_en ? ovr : mem_fn(m_cur)), addr: m_cur});
    end
    if (complete) m_disc = 0;
    else if (f && (m_addr || m_mem)) m_disc = 1;
    m_first = m_addr;
    if (m_addr) m_mem = 1;
    else if (complete) m_mem = 0;
    if (start) begin
      m_cur  = m_next;
      m_next = m_next + 16'd1;
    end
    m_addr = start;
  endtask

  task automatic check_outputs();
    chk("pcOutEn", pcOutEn, m_addr);
    chk("pcCount", pcCount, m_first);
    chk("memReq", memReq, m_mem);
    chk("pc_excl", pcOutEn & pcCount, 0);
    if (m_mem) chk("memAddr", memAddr, m_cur);
    chk("instrValid", instrValid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr", instr, q[0].data);
      chk("instrAddr", instrAddr, q[0].addr);
    end
    if (pcCount === 1'b1) pulses++;
    if (memReq === 1'b1) req_cycles++;
    if (pcOutEn === 1'b1) addr_cycles++;
    if (instrValid === 1'b1) valid_cycles++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_pcOutEn", pcOutEn, 0);
    chk("rst_pcCount", pcCount, 0);
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_instrValid", instrValid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instrAddr", instrAddr, 0);
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, then check the result.
  task automatic cycle(input bit h, input bit f, input bit r, input bit a);
    halt        = h;
    flush       = f;
    memReady    = r;
    instrAccept = a;
    bus         = (pcOutEn === 1'b1) ? pc : 16'($urandom);
    memData     = ovr_en ? ovr : mem_fn(memAddr);
    if (pcCount === 1'b1) pc = pc + 16'd1;
    model_edge(h, f, r, a);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    repeat (6) cycle(1, 0, 1, 1);
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; flush = 1'b0; memReady = 1'b1; instrAccept = 1'b0;
    bus = 16'hFFFF; memData = '0; ovr_en = 0; ovr = '0;
    pulses = 0; req_cycles = 0; addr_cycles = 0; valid_cycles = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Release reset, then a single fetch from 0x0040.
    pc = 16'h0040; m_next = 16'h0040; ovr_en = 1; ovr = 16'hA5C3;
    reset = 1'b1;
    cycle(0, 0, 1, 0);
    chk("release_pcOutEn", pcOutEn, 1);
    cycle(0, 0, 1, 0);
    chk("single_valid_early", instrValid, 0);
    cycle(1, 0, 1, 0);
    chk("single_valid", instrValid, 1);
    chk("single_instr", instr, 16'hA5C3);
    chk("single_addr", instrAddr, 16'h0040);
    chk("single_pccount", pulses, 1);
    ovr_en = 0;
    drain();

    // Three wait states on memReady.
    pulses = 0; req_cycles = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0);
    chk("wait_req_cycles", req_cycles, 4);
    chk("wait_pccount", pulses, 1);
    chk("wait_valid", instrValid, 1);
    chk("wait_addr", instrAddr, 16'h0041);
    drain();

    // Flush in the first MEM cycle; completion two cycles later is dropped.
    ovr_en = 1; ovr = 16'h1234; valid_cycles = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    chk("flush_valid_cycles", valid_cycles, 0);
    ovr_en = 0;
    repeat (3) cycle(0, 0, 1, 0);
    chk("flush_next_valid", instrValid, 1);
    chk("flush_next_addr", instrAddr, 16'h0043);
    chk("flush_next_instr", instr, mem_fn(16'h0043));
    drain();

    // Back-pressure: decoder stalls, fetches stop at DEPTH.
    pc = 16'h0010; m_next = 16'h0010; addr_cycles = 0;
    repeat (12) cycle(0, 0, 1, 0);
    chk("bp_fetches", addr_cycles, DEPTH);
    chk("bp_head_addr", instrAddr, 16'h0010);
    cycle(1, 0, 1, 1);
`ifdef FETCH_PREFETCH_EN
    chk("bp_second_addr", instrAddr, 16'h0011);
`else
    chk("bp_empty", instrValid, 0);
`endif
    drain();

`ifdef FETCH_PREFETCH_EN
    // Push and pop on the same edge with one entry buffered.
    pc = 16'h0100; m_next = 16'h0100;
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 1);
    chk("pp_valid", instrValid, 1);
    chk("pp_addr", instrAddr, 16'h0101);
    chk("pp_instr", instr, mem_fn(16'h0101));
    cycle(1, 0, 0, 1);
    chk("pp_count_one", instrValid, 0);
    drain();
`endif

    // Reset asserted mid-fetch, with a completion arriving during reset.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    memReady = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    model_reset();
    pc = 16'h0200; m_next = 16'h0200;
    reset = 1'b1;
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("post_rst_valid", instrValid, 0);

    repeat (1500)
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
